// File: rtl/aes_gcm_pkg.sv
// Shared types and widths for the AES-GCM tag sequencer and its block counter.
package aes_gcm_pkg;

  localparam int BLK_BITS = 128;
  localparam int LEN_W    = 64;
  localparam int CNT_W    = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRIME     = 3'd1,
    ISSUE_AAD = 3'd2,
    ISSUE_CT  = 3'd3,
    LEN_SLOT  = 3'd4,
    WAIT_TAG  = 3'd5,
    TAG_OUT   = 3'd6
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_LEN      = 2'd1,
    ERR_UNDERRUN = 2'd2,
    ERR_TMO      = 2'd3
  } err_code_t;

endpackage

// File: rtl/aes_gcm_blk_counter.sv
// Slot counter for one GCM job; flags the last AAD slot and the last data slot.
module aes_gcm_blk_counter
  import aes_gcm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_na,
  input  logic [CNT_W-1:0] i_nt,
  output logic             o_last_aad,
  output logic             o_last_data
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_next;

  always_ff @(posedge clk) begin
    if (rst || i_clear) r_cnt <= '0;
    else if (i_inc)     r_cnt <= r_cnt + 1'b1;
  end

  // Compare one ahead in CNT_W+1 bits so NA/NT of 0 or 65535 never wrap.
  assign w_next      = {1'b0, r_cnt} + 1'b1;
  assign o_last_aad  = (w_next == {1'b0, i_na});
  assign o_last_data = (w_next == {1'b0, i_nt});

endmodule

// File: rtl/aes_gcm_tag_sequencer.sv
// Job controller feeding the AES-GCM pipeline: AAD slots, CT slots, length slot, then tag capture/handshake.
module aes_gcm_tag_sequencer
  import aes_gcm_pkg::*;
#(
  parameter int PIPE_LAT  = 8,
  parameter int TMO_SLACK = 4,
  parameter int MAX_BLKS  = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [LEN_W-1:0]    i_aad_len,
  input  logic [LEN_W-1:0]    i_ct_len,
  output logic                o_busy,
  input  logic                i_aad_valid,
  input  logic [BLK_BITS-1:0] i_aad,
  output logic                o_aad_ready,
  input  logic                i_ct_valid,
  input  logic [BLK_BITS-1:0] i_ct,
  output logic                o_ct_ready,
  output logic                o_pipe_valid,
  output logic [BLK_BITS-1:0] o_pipe_aad,
  output logic [BLK_BITS-1:0] o_pipe_ct,
  output logic                o_new_instance,
  output logic [BLK_BITS-1:0] o_instance_size,
  input  logic                i_tag_ready,
  input  logic [BLK_BITS-1:0] i_tag,
  output logic                o_tag_valid,
  output logic [BLK_BITS-1:0] o_tag,
  input  logic                i_tag_ack,
  output logic                o_err,
  output logic [1:0]          o_err_code
);

  localparam int              TMO_W    = $clog2(PIPE_LAT + TMO_SLACK + 1);
  localparam logic [TMO_W-1:0] TMO_INIT = TMO_W'(PIPE_LAT + TMO_SLACK);

  seq_state_t          r_state;
  logic [CNT_W-1:0]    r_na;
  logic [CNT_W-1:0]    r_nt;
  logic                r_first;
  logic [TMO_W-1:0]    r_tmo;
  logic [BLK_BITS-1:0] r_tag;
  logic [BLK_BITS-1:0] r_size;
  err_code_t           r_err_code;

  logic [LEN_W-8:0]    w_na_full;
  logic [LEN_W-8:0]    w_nc_full;
  logic [LEN_W-7:0]    w_nt_full;
  logic                w_len_bad;
  logic                w_start_ok;
  logic                w_issue_aad;
  logic                w_issue_ct;
  logic                w_slot;
  logic                w_last_aad;
  logic                w_last_data;
  logic                w_err;
  err_code_t           w_code;

  // Full-width block counts so oversize lengths are caught before truncation to 16 bits.
  assign w_na_full  = i_aad_len[LEN_W-1:7];
  assign w_nc_full  = i_ct_len[LEN_W-1:7];
  assign w_nt_full  = {1'b0, w_na_full} + {1'b0, w_nc_full};
  assign w_len_bad  = (|(i_aad_len[6:0] | i_ct_len[6:0])) || (w_nt_full > (LEN_W-6)'(MAX_BLKS));
  assign w_start_ok = (r_state == IDLE) && i_start && !w_len_bad;

  assign w_issue_aad = (r_state == ISSUE_AAD) && i_aad_valid;
  assign w_issue_ct  = (r_state == ISSUE_CT) && i_ct_valid;
  assign w_slot      = w_issue_aad || w_issue_ct || (r_state == LEN_SLOT);

  aes_gcm_blk_counter u_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_start_ok),
    .i_inc       (w_issue_aad || w_issue_ct),
    .i_na        (r_na),
    .i_nt        (r_nt),
    .o_last_aad  (w_last_aad),
    .o_last_data (w_last_data)
  );

  always_comb begin
    w_err  = 1'b0;
    w_code = ERR_NONE;
    if (!rst) begin
      case (r_state)
        IDLE:      if (i_start && w_len_bad) begin w_err = 1'b1; w_code = ERR_LEN; end
        ISSUE_AAD: if (!i_aad_valid) begin w_err = 1'b1; w_code = ERR_UNDERRUN; end
        ISSUE_CT:  if (!i_ct_valid) begin w_err = 1'b1; w_code = ERR_UNDERRUN; end
        WAIT_TAG:  if (!i_tag_ready && r_tmo == TMO_W'(1)) begin w_err = 1'b1; w_code = ERR_TMO; end
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_na       <= '0;
      r_nt       <= '0;
      r_first    <= 1'b0;
      r_tmo      <= '0;
      r_tag      <= '0;
      r_size     <= '0;
      r_err_code <= ERR_NONE;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_size     <= {i_aad_len, i_ct_len};
          r_na       <= w_na_full[CNT_W-1:0];
          r_nt       <= w_nt_full[CNT_W-1:0];
          r_first    <= 1'b1;
          r_err_code <= w_len_bad ? ERR_LEN : ERR_NONE;
          if (!w_len_bad) r_state <= PRIME;
        end
        // Hold off the first slot until its source can deliver, so the pipeline never sees a bubble.
        PRIME: begin
          if (r_na != '0) begin
            if (i_aad_valid) r_state <= ISSUE_AAD;
          end else if (r_nt != '0) begin
            if (i_ct_valid) r_state <= ISSUE_CT;
          end else begin
            r_state <= LEN_SLOT;
          end
        end
        ISSUE_AAD: begin
          if (!i_aad_valid) begin
            r_err_code <= ERR_UNDERRUN;
            r_state    <= IDLE;
          end else if (w_last_aad) begin
            r_state <= w_last_data ? LEN_SLOT : ISSUE_CT;
          end
        end
        ISSUE_CT: begin
          if (!i_ct_valid) begin
            r_err_code <= ERR_UNDERRUN;
            r_state    <= IDLE;
          end else if (w_last_data) begin
            r_state <= LEN_SLOT;
          end
        end
        LEN_SLOT: begin
          r_tmo   <= TMO_INIT;
          r_state <= WAIT_TAG;
        end
        WAIT_TAG: begin
          if (i_tag_ready) begin
            r_tag   <= i_tag;
            r_state <= TAG_OUT;
          end else if (r_tmo == TMO_W'(1)) begin
            r_err_code <= ERR_TMO;
            r_state    <= IDLE;
          end else begin
            r_tmo <= r_tmo - 1'b1;
          end
        end
        TAG_OUT: if (i_tag_ack) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_slot) r_first <= 1'b0;
    end
  end

  assign o_busy          = (r_state != IDLE);
  assign o_aad_ready     = w_issue_aad;
  assign o_ct_ready      = w_issue_ct;
  assign o_pipe_valid    = w_slot;
  assign o_pipe_aad      = w_issue_aad ? i_aad : '0;
  assign o_pipe_ct       = w_issue_ct ? i_ct : '0;
  assign o_new_instance  = w_slot && r_first;
  assign o_instance_size = r_size;
  assign o_tag_valid     = (r_state == TAG_OUT);
  assign o_tag           = r_tag;
  assign o_err           = w_err;
  assign o_err_code      = w_err ? w_code : r_err_code;

endmodule

// File: tb/tb_aes_gcm_tag_sequencer.sv
// Scoreboard bench: job driver pushes the expected slot/error/tag sequence, a negedge monitor pops and compares.
module tb_aes_gcm_tag_sequencer;

  localparam int PIPE_LAT  = 8;
  localparam int TMO_SLACK = 4;
  localparam int T_TMO     = PIPE_LAT + TMO_SLACK;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_start = 1'b0;
  logic [63:0]  i_aad_len = '0, i_ct_len = '0;
  logic         o_busy;
  logic         i_aad_valid = 1'b0;
  logic [127:0] i_aad = '0;
  logic         o_aad_ready;
  logic         i_ct_valid = 1'b0;
  logic [127:0] i_ct = '0;
  logic         o_ct_ready;
  logic         o_pipe_valid;
  logic [127:0] o_pipe_aad, o_pipe_ct;
  logic         o_new_instance;
  logic [127:0] o_instance_size;
  logic         i_tag_ready = 1'b0;
  logic [127:0] i_tag = '0;
  logic         o_tag_valid;
  logic [127:0] o_tag;
  logic         i_tag_ack = 1'b0;
  logic         o_err;
  logic [1:0]   o_err_code;

  aes_gcm_tag_sequencer #(.PIPE_LAT(PIPE_LAT), .TMO_SLACK(TMO_SLACK), .MAX_BLKS(65535)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_aad_len(i_aad_len), .i_ct_len(i_ct_len),
    .o_busy(o_busy), .i_aad_valid(i_aad_valid), .i_aad(i_aad), .o_aad_ready(o_aad_ready),
    .i_ct_valid(i_ct_valid), .i_ct(i_ct), .o_ct_ready(o_ct_ready), .o_pipe_valid(o_pipe_valid),
    .o_pipe_aad(o_pipe_aad), .o_pipe_ct(o_pipe_ct), .o_new_instance(o_new_instance),
    .o_instance_size(o_instance_size), .i_tag_ready(i_tag_ready), .i_tag(i_tag),
    .o_tag_valid(o_tag_valid), .o_tag(o_tag), .i_tag_ack(i_tag_ack), .o_err(o_err),
    .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           kind;   // 0 slot, 1 error, 2 tag handshake
    logic [127:0] a;      // aad block / error code / tag
    logic [127:0] b;      // ct block
    logic         ni;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [127:0] exp_size = '0;
  int           nchk = 0;
  int           nfail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (!rst && (o_pipe_valid || o_err || (o_tag_valid && i_tag_ack))) begin
      if (exp_q.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL unexpected_event: got valid=%0b err=%0b tag=%0b expected none (t=%0t)",
                 o_pipe_valid, o_err, o_tag_valid, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_kind", 128'(o_pipe_valid ? 0 : (o_err ? 1 : 2)), 128'(mon_e.kind));
        if (o_pipe_valid) begin
          chk("slot_aad", o_pipe_aad, mon_e.a);
          chk("slot_ct", o_pipe_ct, mon_e.b);
          chk("slot_new_instance", 128'(o_new_instance), 128'(mon_e.ni));
          chk("slot_instance_size", o_instance_size, exp_size);
        end else if (o_err) begin
          chk("err_code", 128'(o_err_code), mon_e.a);
        end else begin
          chk("tag_value", o_tag, mon_e.a);
        end
      end
    end
  end

  task automatic run_job(input logic [63:0] al, input logic [63:0] cl, input int drop_idx,
                         input int tag_dly, input int ack_hold, input int rst_at);
    int na, nc, c, L, aidx, cidx, tv_cnt, err_c, first_c, slots, exp_code;
    bit bad, stop, done, rst_hit;
    logic [127:0] ab[$];
    logic [127:0] cb[$];
    logic [127:0] tagv;
    exp_t e;

    bad = ((al[6:0] | cl[6:0]) != 7'd0) || (((al >> 7) + (cl >> 7)) > 64'd65535);
    na = int'(al >> 7);
    nc = int'(cl >> 7);
    tagv = rnd128();
    exp_code = 0;
    exp_size = {al, cl};
    if (bad) begin
      e.kind = 1; e.a = 128'd1; e.b = '0; e.ni = 1'b0; exp_q.push_back(e);
      exp_code = 1;
    end else begin
      stop = 1'b0;
      for (int i = 0; i < na; i++) ab.push_back(rnd128());
      for (int i = 0; i < nc; i++) cb.push_back(rnd128());
      for (int i = 0; i < na && !stop; i++) begin
        if (i == drop_idx) begin
          e.kind = 1; e.a = 128'd2; e.b = '0; e.ni = 1'b0; stop = 1'b1; exp_code = 2;
        end else begin
          e.kind = 0; e.a = ab[i]; e.b = '0; e.ni = (i == 0);
        end
        exp_q.push_back(e);
      end
      if (!stop) begin
        for (int i = 0; i < nc; i++) begin
          e.kind = 0; e.a = '0; e.b = cb[i]; e.ni = (na == 0 && i == 0); exp_q.push_back(e);
        end
        e.kind = 0; e.a = '0; e.b = '0; e.ni = (na + nc == 0); exp_q.push_back(e);
        if (tag_dly < 0) begin
          e.kind = 1; e.a = 128'd3; e.ni = 1'b0; exp_code = 3;
        end else begin
          e.kind = 2; e.a = tagv; e.ni = 1'b0;
        end
        exp_q.push_back(e);
      end
    end

    @(posedge clk); #1;
    i_start = 1'b1; i_aad_len = al; i_ct_len = cl;
    @(posedge clk); #1;
    i_start = 1'b0;

    if (bad) begin
      for (int k = 0; k < 3; k++) begin
        chk("badlen_busy", 128'(o_busy), 128'd0);
        @(posedge clk); #1;
      end
      chk("badlen_queue_empty", 128'(exp_q.size()), 128'd0);
      chk("badlen_code_held", 128'(o_err_code), 128'd1);
      return;
    end

    c = 1; L = -1; aidx = 0; cidx = 0; tv_cnt = 0; err_c = -1; first_c = -1; slots = 0;
    done = 1'b0; rst_hit = 1'b0;
    while (!done) begin
      i_aad_valid = (aidx != drop_idx);
      i_aad       = (aidx < na) ? ab[aidx] : rnd128();
      i_ct_valid  = 1'b1;
      i_ct        = (cidx < nc) ? cb[cidx] : rnd128();
      i_tag_ready = (L < 0) ? 1'($urandom_range(0, 1)) : (tag_dly >= 0 && c == L + tag_dly);
      i_tag       = (L < 0) ? rnd128() : tagv;
      i_tag_ack   = o_tag_valid && (tv_cnt >= ack_hold);
      i_start     = (o_tag_valid && !i_tag_ack) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (c == rst_at) rst = 1'b1;
      #1;
      if (o_pipe_valid) begin
        slots++;
        if (slots == 1) first_c = c;
        if (slots == na + nc + 1) L = c;
      end
      if (o_err) err_c = c;
      if (o_tag_valid) begin
        chk("tag_stable", o_tag, tagv);
        tv_cnt++;
      end
      if (o_aad_ready) aidx++;
      if (o_ct_ready) cidx++;
      @(posedge clk); #1;
      c++;
      if (rst) begin
        rst = 1'b0; i_tag_ready = 1'b0; i_start = 1'b0; i_tag_ack = 1'b0;
        #1;
        chk("reset_midjob_outputs_zero",
            {o_busy, o_aad_ready, o_ct_ready, o_pipe_valid, o_new_instance, o_tag_valid, o_err,
             o_err_code, o_pipe_aad ^ o_pipe_ct ^ o_instance_size ^ o_tag}, '0);
        exp_q.delete();
        rst_hit = 1'b1;
        done = 1'b1;
      end else if (!o_busy) begin
        done = 1'b1;
      end else if (c > 400) begin
        nchk++;
        nfail++;
        $display("FAIL job_timeout: got busy after %0d cycles expected idle", c);
        done = 1'b1;
      end
    end
    i_tag_ready = 1'b0; i_tag_ack = 1'b0; i_start = 1'b0;

    chk("first_slot_latency", 128'(first_c), 128'd2);
    if (!rst_hit) begin
      chk("queue_empty", 128'(exp_q.size()), 128'd0);
      chk("err_code_held", 128'(o_err_code), 128'(exp_code));
      chk("tag_valid_dropped", 128'(o_tag_valid), 128'd0);
      if (exp_code == 2) chk("underrun_cycle", 128'(err_c), 128'(2 + drop_idx));
      if (exp_code == 3) chk("timeout_cycle", 128'(err_c - L), 128'(T_TMO));
      if (exp_code != 0) chk("idle_after_err", 128'(c), 128'(err_c + 1));
      if (exp_code == 0) chk("ack_hold_cycles", 128'(tv_cnt), 128'(ack_hold + 1));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_outputs_zero",
        {o_busy, o_aad_ready, o_ct_ready, o_pipe_valid, o_new_instance, o_tag_valid, o_err,
         o_err_code, o_pipe_aad ^ o_pipe_ct ^ o_instance_size ^ o_tag}, '0);

    run_job(64'd256, 64'd384, -1, PIPE_LAT, 0, -1);
    run_job(64'd0, 64'd0, -1, PIPE_LAT, 0, -1);
    run_job(64'd100, 64'd0, -1, PIPE_LAT, 0, -1);
    run_job(64'd40000 * 64'd128, 64'd25536 * 64'd128, -1, PIPE_LAT, 0, -1);
    run_job(64'd384, 64'd128, 1, PIPE_LAT, 0, -1);
    run_job(64'd128, 64'd256, -1, -1, 0, -1);
    run_job(64'd256, 64'd256, -1, T_TMO, 10, -1);
    run_job(64'd0, 64'd384, -1, 1, 0, -1);
    run_job(64'd128, 64'd512, -1, PIPE_LAT, 0, 4);
    for (int j = 0; j < 12; j++) begin
      run_job(64'($urandom_range(0, 4)) * 64'd128, 64'($urandom_range(0, 4)) * 64'd128, -1,
              int'($urandom_range(1, T_TMO)), int'($urandom_range(0, 3)), -1);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
